// File: rtl/regfile_bank_2w.sv
// Storage stage of the two-read/two-write register file.
// Holds 2**Bits registers of Width bits, commits up to two writes per cycle
// (port B wins on a same-address collision) and exposes every register on a
// flattened bus that feeds both 32:1 read muxes. Also keeps a per-register
// dirty mask and a saturating collision counter for debug.
// All outputs come straight from flops or constants.

module regfile_bank_2w #(
    parameter int unsigned Bits     = 5,
    parameter int unsigned Width    = 32,
    parameter bit          ZeroReg  = 1'b1,
    parameter int unsigned CntWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_a,
    input  logic [Bits-1:0]            waddr_a,
    input  logic [Width-1:0]           wdata_a,
    input  logic                       we_b,
    input  logic [Bits-1:0]            waddr_b,
    input  logic [Width-1:0]           wdata_b,
    input  logic                       clr_dirty,
    output logic [(2**Bits)*Width-1:0] q_flat,
    output logic [2**Bits-1:0]         dirty,
    output logic                       collision,
    output logic [CntWidth-1:0]        coll_cnt
);

    localparam int unsigned NumRegs = 2 ** Bits;

    logic               eff_a;
    logic               eff_b;
    logic [NumRegs-1:0] wsel_a;
    logic [NumRegs-1:0] wsel_b;
    logic [NumRegs-1:0] one_hot_lsb;

    logic [NumRegs-1:0]  dirty_q;
    logic [NumRegs-1:0]  dirty_d;
    logic                collision_q;
    logic                collision_d;
    logic [CntWidth-1:0] coll_cnt_q;
    logic [CntWidth-1:0] coll_cnt_d;

    // Effective-write qualification and one-hot write decode per port.
    always_comb begin
        one_hot_lsb = '0;
        one_hot_lsb[0] = 1'b1;
        // A write to reg 0 is silently dropped when it is hardwired to zero.
        eff_a = we_a && !(ZeroReg && (waddr_a == '0));
        eff_b = we_b && !(ZeroReg && (waddr_b == '0));
        wsel_a = eff_a ? (one_hot_lsb << waddr_a) : '0;
        wsel_b = eff_b ? (one_hot_lsb << waddr_b) : '0;
        collision_d = eff_a && eff_b && (waddr_a == waddr_b);
    end

    // Register storage; reg 0 is a constant when ZeroReg is set.
    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        if (ZeroReg && (i == 0)) begin : g_zero
            assign q_flat[i*Width +: Width] = '0;
        end else begin : g_store
            logic [Width-1:0] data_q;

            // Port B is checked first so it wins a same-address collision.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (wsel_b[i]) begin
                    data_q <= wdata_b;
                end else if (wsel_a[i]) begin
                    data_q <= wdata_a;
                end
            end

            assign q_flat[i*Width +: Width] = data_q;
        end
    end

    // Next-state for dirty mask (set beats clear) and saturating counter.
    always_comb begin
        if (clr_dirty) begin
            dirty_d = wsel_a | wsel_b;
        end else begin
            dirty_d = dirty_q | wsel_a | wsel_b;
        end
        coll_cnt_d = coll_cnt_q;
        if (collision_d && (coll_cnt_q != '1)) begin
            coll_cnt_d = coll_cnt_q + CntWidth'(1);
        end
    end

    // Dirty mask, collision pulse and counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dirty_q     <= '0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            dirty_q     <= dirty_d;
            collision_q <= collision_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    assign dirty     = dirty_q;
    assign collision = collision_q;
    assign coll_cnt  = coll_cnt_q;

endmodule
